pipe_barrel_shifter: RTL and testbench

//  Parametrised, pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR) for the multicycle/pipelined datapath.

---
 rtl/shift_pkg.sv | 10 +
 rtl/shift_rank.sv | 81 ++++++++
 rtl/pipe_barrel_shifter.sv | 98 +++++++++
 tb/tb_pipe_barrel_shifter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shift type encoding and out-of-range amount helper for pipe_barrel_shifter
package shift_pkg;

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shtype_e;

    function automatic logic shamt_sat(input logic [31:0] n, input logic [31:0] w);
        return n >= w;
    endfunction

endpackage

// File: rtl/shift_rank.sv
// shift_rank: one elastic pipeline rank applying log-shift steps LO..HI-1 then registering the result
// Carries the shifter carry bit alongside the data when SHIFTER_CARRY_EN is defined.
module shift_rank
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LW    = 5,
    parameter int LO    = 0,
    parameter int HI    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  shtype_e          in_type,
    input  logic [LW-1:0]    in_amt,
`ifdef SHIFTER_CARRY_EN
    input  logic             in_carry,
    output logic             out_carry,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output shtype_e          out_type,
    output logic [LW-1:0]    out_amt
);

    logic [WIDTH-1:0] w_shifted;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    shtype_e          r_type;
    logic [LW-1:0]    r_amt;

    // ASR fills with the current MSB, which earlier ASR steps have kept equal to the sign
    always_comb begin
        w_shifted = in_data;
        for (int i = LO; i < HI; i++) begin
            if (in_amt[i]) begin
                w_shifted = in_type == SH_LSL ? w_shifted << (1 << i)
                          : in_type == SH_ROR ? (w_shifted >> (1 << i)) | (w_shifted << (WIDTH - (1 << i)))
                          : (w_shifted >> (1 << i)) | ({WIDTH{in_type == SH_ASR && w_shifted[WIDTH-1]}} << (WIDTH - (1 << i)));
            end
        end
    end

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_type  = r_type;
    assign out_amt   = r_amt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_valid <= 1'b0;
        else if (in_ready) r_valid <= in_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_type <= SH_LSL;
            r_amt  <= '0;
        end else if (in_ready && in_valid) begin
            r_data <= w_shifted;
            r_type <= in_type;
            r_amt  <= in_amt;
        end
    end

`ifdef SHIFTER_CARRY_EN
    logic r_carry;

    assign out_carry = r_carry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_carry <= 1'b0;
        else if (in_ready && in_valid) r_carry <= in_carry;
    end
`endif

endmodule

// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter: pipelined ARM-style LSL/LSR/ASR/ROR shifter with elastic valid/ready ranks
// Define SHIFTER_CARRY_EN to produce the ARM shifter carry-out; otherwise out_carry is tied to 0.
module pipe_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8,
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_type,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry
);

    localparam int LW = $clog2(WIDTH);
    localparam int P  = LW / STAGES;

    logic [STAGES:0]            w_valid;
    logic [STAGES:0]            w_ready;
    logic [STAGES:0][WIDTH-1:0] w_data;
    shtype_e [STAGES:0]         w_type;
    logic [STAGES:0][LW-1:0]    w_amt;
    shtype_e                    w_in_type;
    logic                       w_sat;
    logic                       w_clip;
    logic                       w_unused;

    // Out-of-range LSL/LSR/ASR resolve here to their final value; ROR only keeps n mod WIDTH
    assign w_in_type = shtype_e'(in_type);
    assign w_sat     = shamt_sat(32'(in_shamt), WIDTH);
    assign w_clip    = w_sat && w_in_type != SH_ROR;
    assign w_valid[0] = in_valid;
    assign in_ready   = w_ready[0];
    assign w_data[0]  = w_clip ? {WIDTH{w_in_type == SH_ASR && in_data[WIDTH-1]}} : in_data;
    assign w_type[0]  = w_in_type;
    assign w_amt[0]   = w_clip ? '0 : in_shamt[LW-1:0];
    assign w_ready[STAGES] = out_ready;
    assign out_valid = w_valid[STAGES];
    assign out_data  = w_data[STAGES];

`ifdef SHIFTER_CARRY_EN
    logic [STAGES:0] w_carry;
    logic [LW-1:0]   w_dec;
    logic [LW-1:0]   w_neg;
    logic            w_le;

    // n-1 mod WIDTH covers LSR/ASR/ROR bit picks; WIDTH-n mod WIDTH covers LSL
    assign w_dec = in_shamt[LW-1:0] - LW'(1);
    assign w_neg = LW'(0) - in_shamt[LW-1:0];
    assign w_le  = !shamt_sat(32'(in_shamt), WIDTH + 1);
    assign w_carry[0] = in_shamt == '0 ? in_carry
                      : w_in_type == SH_LSL ? w_le && in_data[w_neg]
                      : w_in_type == SH_LSR ? w_le && in_data[w_dec]
                      : w_in_type == SH_ASR && w_sat ? in_data[WIDTH-1]
                      : in_data[w_dec];
    assign out_carry = w_carry[STAGES];
    assign w_unused  = ^{w_type[STAGES], w_amt[STAGES]};
`else
    assign out_carry = 1'b0;
    assign w_unused  = ^{w_type[STAGES], w_amt[STAGES], in_carry};
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        shift_rank #(
            .WIDTH(WIDTH),
            .LW   (LW),
            .LO   (k * P),
            .HI   (k == STAGES - 1 ? LW : (k + 1) * P)
        ) u_rank (
            .clk      (clk),
            .reset    (reset),
            .in_valid (w_valid[k]),
            .in_ready (w_ready[k]),
            .in_data  (w_data[k]),
            .in_type  (w_type[k]),
            .in_amt   (w_amt[k]),
`ifdef SHIFTER_CARRY_EN
            .in_carry (w_carry[k]),
            .out_carry(w_carry[k+1]),
`endif
            .out_valid(w_valid[k+1]),
            .out_ready(w_ready[k+1]),
            .out_data (w_data[k+1]),
            .out_type (w_type[k+1]),
            .out_amt  (w_amt[k+1])
        );
    end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter: directed and random checks of pipe_barrel_shifter (WIDTH=32, STAGES=2)
module tb_pipe_barrel_shifter;

`ifdef SHIFTER_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_type;
    logic [7:0]  in_shamt;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_sent = 0;
    int          n_out = 0;
    logic [32:0] exp_q[$];
    logic        done;
    int          base;
    logic [31:0] rd;
    logic [1:0]  rt;
    logic [7:0]  rn;
    logic        rc;

    always #5 clk = ~clk;

    pipe_barrel_shifter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_type  (in_type),
        .in_shamt (in_shamt),
        .in_carry (in_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] d, input logic [1:0] t, input int n, input logic c);
        logic [31:0] r;
        logic        co;
        int          steps;
        r = d;
        steps = t == 2'd3 ? n % 32 : (n > 32 ? 32 : n);
        for (int s = 0; s < steps; s++)
            r = t == 2'd0 ? r << 1 : t == 2'd1 ? r >> 1 : t == 2'd2 ? {r[31], r[31:1]} : {r[0], r[31:1]};
        if (n == 0) co = c;
        else if (t == 2'd0) begin
            if (n <= 32) co = d[32-n];
            else co = 1'b0;
        end else if (t == 2'd1) begin
            if (n <= 32) co = d[n-1];
            else co = 1'b0;
        end else if (t == 2'd2) begin
            if (n >= 32) co = d[31];
            else co = d[n-1];
        end else begin
            if (n % 32 == 0) co = d[31];
            else co = d[n%32-1];
        end
        return {co & CEN, r};
    endfunction

    task automatic send(input logic [31:0] d, input logic [1:0] t, input logic [7:0] n, input logic c,
                        input logic [32:0] e);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_type  = t;
        in_shamt = n;
        in_carry = c;
        #2;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            #2;
            w++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        else begin
            exp_q.push_back(e);
            n_sent++;
            @(posedge clk);
        end
    endtask

    task automatic vec(input logic [1:0] t, input logic [7:0] n, input logic c, input logic [31:0] d,
                       input logic [31:0] ed, input logic ec);
        send(d, t, n, c, {ec & CEN, ed});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int w = 0; w < 400 && n_out != n_sent; w++) @(negedge clk);
        chk(tag, n_out, n_sent);
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation
    always @(posedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("extra_out", exp_q.size(), 1);
            else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e[31:0]);
                chk("out_carry", out_carry, e[32]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_type   = '0;
        in_shamt  = '0;
        in_carry  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_carry", out_carry, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: latency of one LSL
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h8000_0001; in_type = 2'd0; in_shamt = 8'd1; in_carry = 1'b0;
        #2;
        chk("s1_in_ready", in_ready, 1);
        exp_q.push_back({CEN, 32'h0000_0002});
        n_sent++;
        @(posedge clk);
        #1 chk("s1_lat1", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("s1_lat2", out_valid, 1);
        chk("s1_data", out_data, 32'h0000_0002);
        chk("s1_carry", out_carry, CEN);
        drain("s1_drain");

        // Scenarios 2/3 plus boundaries, back-to-back
        vec(2'd2, 8'd40,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        vec(2'd1, 8'd40,  1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0);
        vec(2'd1, 8'd32,  1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1);
        vec(2'd3, 8'd36,  1'b0, 32'h0000_00F1, 32'h1000_000F, 1'b0);
        vec(2'd3, 8'd32,  1'b0, 32'h0000_00F1, 32'h0000_00F1, 1'b0);
        vec(2'd3, 8'd0,   1'b1, 32'h0000_00F1, 32'h0000_00F1, 1'b1);
        vec(2'd0, 8'd32,  1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1);
        vec(2'd0, 8'd33,  1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0);
        vec(2'd2, 8'd31,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        vec(2'd2, 8'd40,  1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0);
        vec(2'd1, 8'd4,   1'b0, 32'hF000_0000, 32'h0F00_0000, 1'b0);
        vec(2'd1, 8'd4,   1'b0, 32'h0000_0018, 32'h0000_0001, 1'b1);
        vec(2'd2, 8'd5,   1'b0, 32'h8000_0010, 32'hFC00_0000, 1'b1);
        vec(2'd0, 8'd0,   1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1);
        vec(2'd3, 8'd1,   1'b0, 32'h8000_0001, 32'hC000_0000, 1'b1);
        vec(2'd3, 8'd8,   1'b1, 32'h1234_5678, 32'h7812_3456, 1'b0);
        vec(2'd0, 8'd255, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0);
        vec(2'd1, 8'd200, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0);
        vec(2'd3, 8'd255, 1'b0, 32'h4000_0001, 32'h8000_0002, 1'b1);
        idle();
        drain("s23_drain");

        // Scenario 4: random ops against the model with random backpressure
        done = 1'b0;
        fork
            begin
                for (int j = 0; j < 100; j++) begin
                    rd = $urandom;
                    rt = 2'($urandom_range(0, 3));
                    rn = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
                    rc = 1'($urandom_range(0, 1));
                    send(rd, rt, rn, rc, model(rd, rt, int'(rn), rc));
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain("s4_drain");

        // Scenario 5: stall output, pipeline fills, then drains in order
        @(negedge clk);
        out_ready = 1'b0;
        base = n_sent;
        fork
            begin
                vec(2'd0, 8'd4, 1'b0, 32'h0000_0001, 32'h0000_0010, 1'b0);
                vec(2'd1, 8'd8, 1'b0, 32'h0000_0100, 32'h0000_0001, 1'b0);
                vec(2'd3, 8'd1, 1'b0, 32'h0000_0003, 32'h8000_0001, 1'b1);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                #3 chk("s5_hold1", out_data, 32'h0000_0010);
                repeat (3) @(negedge clk);
                #3;
                chk("s5_accepted", n_sent - base, 2);
                chk("s5_in_ready", in_ready, 0);
                chk("s5_out_valid", out_valid, 1);
                chk("s5_hold2", out_data, 32'h0000_0010);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("s5_drain");

        // Scenario 6: reset with two operations in flight
        base = n_out;
        vec(2'd0, 8'd1, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        vec(2'd1, 8'd1, 1'b0, 32'h0000_0004, 32'h0000_0002, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("s6_out_valid", out_valid, 0);
        chk("s6_in_ready", in_ready, 1);
        chk("s6_out_data", out_data, 0);
        in_valid = 1'b0;
        exp_q.delete();
        n_sent = n_out;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("s6_quiet", n_out, base);
        chk("s6_no_valid", out_valid, 0);
        vec(2'd2, 8'd4, 1'b0, 32'h8000_0000, 32'hF800_0000, 1'b0);
        idle();
        drain("s6_recover");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
